// File: rtl/demux4way32_reg_pkg.sv
// Shared constants for the registered 1-to-4 word demultiplexer.
package demux4way32_reg_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int NUM_OUTS  = 4;

  localparam logic [1:0] SEL_OUT1 = 2'b00;
  localparam logic [1:0] SEL_OUT2 = 2'b01;
  localparam logic [1:0] SEL_OUT3 = 2'b10;
  localparam logic [1:0] SEL_OUT4 = 2'b11;

  // One-hot destination decode, bit i-1 = outi.
  function automatic logic [NUM_OUTS-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_OUTS-1:0] oh;
    oh = '0;
    case (sel)
      SEL_OUT1: oh = 4'b0001;
      SEL_OUT2: oh = 4'b0010;
      SEL_OUT3: oh = 4'b0100;
      SEL_OUT4: oh = 4'b1000;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux4way32_reg_slot.sv
// One-entry holding slot: full flag plus data register with valid/ready drain.
module demux_slot
  import demux4way32_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout
);

  logic full;
  logic drain;

  assign drain     = full & out_ready;
  assign out_valid = full;

  // load is only raised when the slot is empty or draining, so a load
  // always wins and refills without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4way32_reg.sv
// Registered 1-to-4 demux: one producer steered by in_sel into four slots.
module demux4way32_reg
  import demux4way32_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4
);

  logic [NUM_OUTS-1:0]            load;
  logic [NUM_OUTS-1:0][WIDTH-1:0] dout;
  logic                           accept;

  // Ready depends only on the selected slot, never on in_valid.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign load     = accept ? sel_onehot(in_sel) : '0;

  for (genvar i = 0; i < NUM_OUTS; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .din       (in_data),
      .out_ready (out_ready[i]),
      .out_valid (out_valid[i]),
      .dout      (dout[i])
    );
  end

  assign out1 = dout[0];
  assign out2 = dout[1];
  assign out3 = dout[2];
  assign out4 = dout[3];

endmodule

// File: tb/tb_demux4way32_reg.sv
// Directed and random checks for demux4way32_reg.
module tb_demux4way32_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out1, out2, out3, out4;
  logic [31:0] outs [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux4way32_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4)
  );

  always_comb begin
    outs[0] = out1;
    outs[1] = out2;
    outs[2] = out3;
    outs[3] = out4;
  end

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 2'b00; out_ready = 4'b0000;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_valid: got %b want 0000", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (outs[i] !== 32'h0) begin
        n_err++; $display("FAIL reset_out%0d: got %h want 00000000", i + 1, outs[i]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL reset_ready_sel%0d: got %b want 1", s, in_ready);
      end
    end
  endtask

  task automatic test_steering();
    logic [31:0] vals [4];
    logic [3:0]  exp_v;
    vals[0] = 32'hDEADBEEF; vals[1] = 32'h11111111;
    vals[2] = 32'h22222222; vals[3] = 32'h33333333;
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = vals[k];
      step();
      exp_v = 4'b0001 << k;
      n_cmp++;
      if (out_valid !== exp_v) begin
        n_err++; $display("FAIL steer_valid%0d: got %b want %b", k, out_valid, exp_v);
      end
      n_cmp++;
      if (outs[k] !== vals[k]) begin
        n_err++; $display("FAIL steer_data%0d: got %h want %h", k, outs[k], vals[k]);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL steer_drained: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1110;
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'hA5A5A5A5;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_first: got %b want 1", in_ready);
    end
    step();
    in_data = 32'h5A5A5A5A;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_ready_stall: got %b want 0", in_ready);
    end
    step();
    n_cmp++;
    if (out1 !== 32'hA5A5A5A5 || out_valid[0] !== 1'b1) begin
      n_err++; $display("FAIL bp_hold: got %h/%b want a5a5a5a5/1", out1, out_valid[0]);
    end
    out_ready = 4'b1111;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_release: got %b want 1", in_ready);
    end
    step();
    n_cmp++;
    if (out1 !== 32'h5A5A5A5A || out_valid[0] !== 1'b1) begin
      n_err++; $display("FAIL bp_refill: got %h/%b want 5a5a5a5a/1", out1, out_valid[0]);
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL bp_drained: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_independence();
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'hBBBB0002;
    step();
    for (int k = 1; k <= 4; k++) begin
      in_sel = 2'b10; in_data = 32'(k);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL indep_ready%0d: got %b want 1", k, in_ready);
      end
      step();
      n_cmp++;
      if (out3 !== 32'(k) || out_valid[2] !== 1'b1) begin
        n_err++; $display("FAIL indep_out3_%0d: got %h/%b want %h/1", k, out3, out_valid[2], 32'(k));
      end
      n_cmp++;
      if (out2 !== 32'hBBBB0002 || out_valid[1] !== 1'b1) begin
        n_err++; $display("FAIL indep_out2_%0d: got %h/%b want bbbb0002/1", k, out2, out_valid[1]);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 4'b0010) begin
      n_err++; $display("FAIL indep_final: got %b want 0010", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h00000010;
    step();
    in_sel = 2'b10; in_data = 32'h00000030;
    step();
    n_cmp++;
    if (out_valid !== 4'b0111) begin
      n_err++; $display("FAIL mrst_pre: got %b want 0111", out_valid);
    end
    in_sel = 2'b11; in_data = 32'h00000099; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL mrst_valid: got %b want 0000", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (outs[i] !== 32'h0) begin
        n_err++; $display("FAIL mrst_out%0d: got %h want 00000000", i + 1, outs[i]);
      end
    end
    step();
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL mrst_after: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_random();
    logic        mfull [4];
    logic [31:0] mdata [4];
    logic [31:0] pdata [4];
    logic [3:0]  pvalid, pready;
    logic        exp_rdy, acc;
    for (int i = 0; i < 4; i++) begin
      mfull[i] = 1'b0; mdata[i] = 32'h0;
    end
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 4'($urandom_range(0, 15));
      #1;
      exp_rdy = ~mfull[in_sel] | out_ready[in_sel];
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, exp_rdy);
      end
      for (int i = 0; i < 4; i++) pdata[i] = outs[i];
      pvalid = out_valid;
      pready = out_ready;
      acc = in_valid & exp_rdy;
      for (int i = 0; i < 4; i++) begin
        if (acc && in_sel == 2'(i)) begin
          mfull[i] = 1'b1; mdata[i] = in_data;
        end else if (mfull[i] && out_ready[i]) begin
          mfull[i] = 1'b0;
        end
      end
      step();
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (out_valid[i] !== mfull[i] || outs[i] !== mdata[i]) begin
          n_err++;
          $display("FAIL rnd_slot%0d c%0d: got %b/%h want %b/%h",
                   i, c, out_valid[i], outs[i], mfull[i], mdata[i]);
        end
        if (pvalid[i] && !pready[i]) begin
          n_cmp++;
          if (out_valid[i] !== 1'b1 || outs[i] !== pdata[i]) begin
            n_err++;
            $display("FAIL rnd_stable%0d c%0d: got %b/%h want 1/%h",
                     i, c, out_valid[i], outs[i], pdata[i]);
          end
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 4'h0;
  endtask

  initial begin
    test_reset();
    test_steering();
    test_backpressure();
    test_independence();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
